// File: rtl/corr_pkg.sv
// corr_pkg: shared pair-primitive helpers for the chain decoder and its bench.
// Pairs are packed {odd, even}, bit 2k+1 over bit 2k.
package corr_pkg;

  localparam int PairW = 2;

  function automatic logic [PairW-1:0] invPair(
    input logic [PairW-1:0] x
  );
    logic evenN;
    evenN = ~x[0];
    return {x[1] ^ evenN, evenN};
  endfunction

  // Forward chain primitive; invPair(fwdPair(x)) == x.
  function automatic logic [PairW-1:0] fwdPair(
    input logic [PairW-1:0] x
  );
    return {x[1] ^ x[0], ~x[0]};
  endfunction

endpackage

// File: rtl/corr_dec_stage.sv
// corr_dec_stage: one registered inverse-pair stage with valid/ready.
// CORR_DEC_CHECK_EN adds a golden word carried alongside the data.
module corr_dec_stage
  import corr_pkg::*;
#(
  parameter int IO_PAIRS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upValid,
  output logic                      upReady,
  input  logic [PairW*IO_PAIRS-1:0] upData,
`ifdef CORR_DEC_CHECK_EN
  input  logic [PairW*IO_PAIRS-1:0] upGolden,
  output logic [PairW*IO_PAIRS-1:0] golden,
`endif
  output logic                      valid,
  input  logic                      dnReady,
  output logic [PairW*IO_PAIRS-1:0] data
);

  localparam int W = PairW * IO_PAIRS;

  logic [W-1:0] nextData;

  always_comb begin
    nextData = '0;
    for (int k = 0; k < IO_PAIRS; k++) begin
      nextData[PairW*k +: PairW] =
        invPair(upData[PairW*k +: PairW]);
    end
  end

  // Empty stage or draining downstream lets a word in.
  assign upReady = ~valid | dnReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (upReady) begin
      valid <= upValid;
      if (upValid) begin
        data <= nextData;
      end
    end
  end

`ifdef CORR_DEC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden <= '0;
    end else if (upReady && upValid) begin
      golden <= upGolden;
    end
  end
`endif

endmodule

// File: rtl/corr_chain_decoder.sv
// corr_chain_decoder: DEPTH-stage elastic pipeline inverting the pair chain.
// Define CORR_DEC_CHECK_EN to add golden compare (s_golden, err_count, err_flag).
module corr_chain_decoder
  import corr_pkg::*;
#(
  parameter int IO_PAIRS = 4,
  parameter int DEPTH    = 8
`ifdef CORR_DEC_CHECK_EN
  , parameter int ERR_W  = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [PairW*IO_PAIRS-1:0] s_data,
`ifdef CORR_DEC_CHECK_EN
  input  logic [PairW*IO_PAIRS-1:0] s_golden,
  output logic [ERR_W-1:0]          err_count,
  output logic                      err_flag,
`endif
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PairW*IO_PAIRS-1:0] m_data
);

  localparam int W = PairW * IO_PAIRS;

  logic [DEPTH:0] vld;
  logic [DEPTH:0] rdy;
  logic [W-1:0]   dat [DEPTH+1];
`ifdef CORR_DEC_CHECK_EN
  logic [W-1:0]   gld [DEPTH+1];
  assign gld[0] = s_golden;
`endif

  assign vld[0]     = s_valid;
  assign dat[0]     = s_data;
  assign rdy[DEPTH] = m_ready;

  // Index i feeds stage i; index DEPTH is the output port.
  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    corr_dec_stage #(
      .IO_PAIRS(IO_PAIRS)
    ) uStage (
      .clk     (clk),
      .rst     (rst),
      .upValid (vld[i]),
      .upReady (rdy[i]),
      .upData  (dat[i]),
`ifdef CORR_DEC_CHECK_EN
      .upGolden(gld[i]),
      .golden  (gld[i+1]),
`endif
      .valid   (vld[i+1]),
      .dnReady (rdy[i+1]),
      .data    (dat[i+1])
    );
  end

  assign s_ready = rdy[0];
  assign m_valid = vld[DEPTH];
  assign m_data  = dat[DEPTH];

`ifdef CORR_DEC_CHECK_EN
  logic mismatch;

  assign mismatch = m_valid & m_ready & (m_data != gld[DEPTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      if (err_count != '1) begin
        err_count <= err_count + 1'b1;
      end
    end
  end
`endif

endmodule
